dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-master arbiter in front of the single data-memory port (combinational read, posedge write).
//  M0 is the pipeline LSU; M1 is the UART bridge (program/data loader, debug peek/poke).
//  Grants one single-cycle word access per clock, round-robin on conflict, with optional bounded lock for bursts.
//  Registers read data into a per-master response and raises the LSU stall while M0 waits.
// PARAMETERS
//  ADDR_W     32      byte-address width on both master ports
//  DATA_W     32      word width (mem access is one word, little-endian byte order in memory)
//  BASE_ADDR  32'h0   first byte address decoded to the memory
//  MEM_BYTES  2048    decoded window size in bytes; memory index is addr[10:0] (power of two)
//  MAX_BURST  8       max consecutive locked grants to one master before forced release
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  m0_req/m1_req     in   1       access request, held until granted
//  m0_we/m1_we       in   1       1 = write, 0 = read
//  m0_lock/m1_lock   in   1       keep ownership after this beat (burst)
//  m0_addr/m1_addr   in   ADDR_W  byte address, word aligned
//  m0_wdata/m1_wdata in   DATA_W  write data
//  m0_gnt/m1_gnt     out  1       combinational grant; beat completes at this clk edge
//  m0_rvalid/m1_rvalid out 1      one-cycle pulse, read data valid (cycle after grant)
//  m0_rdata/m1_rdata out  DATA_W  registered read data, held until next rvalid for that master
//  m0_err/m1_err     out  1       one-cycle pulse (cycle after grant): out-of-window or misaligned
//  lsu_stall    out  1       m0_req & ~m0_gnt
//  mem_sel, mem_rd_en, mem_wr_en  out 1  memory strobes
//  mem_addr     out  ADDR_W  granted address
//  mem_wdata    out  DATA_W  granted write data
//  mem_rdata    in   DATA_W  combinational memory read data
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, last_gnt=M1 (M0 wins first tie), burst_cnt=0;
//   all rvalid/err=0, rdata=0; gnt and mem strobes 0 while in reset.
//  At most one gnt per cycle. A master's gnt never asserts without its req.
//  FSM: IDLE, LOCK0, LOCK1.
//   IDLE: one req -> grant it; both -> grant master != last_gnt. last_gnt updates on every grant.
//    Granted beat with lock=1 -> LOCKx, burst_cnt=1.
//   LOCKx: only master x may be granted; other master waits (M0 waiting -> lsu_stall=1).
//    x granted with lock=1 and burst_cnt<MAX_BURST-1 -> stay, burst_cnt++.
//    x granted with lock=0, or burst_cnt reaches MAX_BURST on this beat -> IDLE;
//     forced release sets last_gnt=x so other master wins the next tie.
//    x req=0 in LOCKx -> no grant this cycle, go IDLE (lock abandoned).
//  Decode: hit = addr in [BASE_ADDR, BASE_ADDR+MEM_BYTES-4] and addr[1:0]==0.
//   Granted hit: mem_sel=1; mem_wr_en=we; mem_rd_en=~we; mem_addr/mem_wdata muxed from owner.
//   Granted miss: beat consumed, mem_sel=0, no write.
//    Read miss: rvalid=1, rdata=0, err=1 next cycle. Write miss: err=1 only.
//  No grant: mem_sel/rd_en/wr_en=0; mem_addr/wdata hold don't-care (drive 0).
//  Read latency: grant cycle N -> mem_rdata captured at edge N -> rvalid/rdata visible cycle N+1.
//   Back-to-back reads by one master give back-to-back rvalid pulses.
//  Write: committed by memory at edge of grant cycle; no response pulse on success.
//  Read-after-write same address, consecutive grants: read returns new data.
//  Reset mid-burst: FSM to IDLE, pending rvalid/err dropped, no response replayed.
// TESTING
//  M0 only, write 0xDEADBEEF @0x10 then read @0x10 -> gnt both cycles, m0_rvalid cycle+1, m0_rdata=0xDEADBEEF.
//  Both req every cycle, no lock -> grants alternate M0,M1,M0,...; lsu_stall=1 on M1 cycles; first grant M0.
//  M1 lock=1 for 20 beats, M0 req constant, MAX_BURST=8 -> 8 M1 grants, 1 M0 grant, then M1 relocks.
//  M0 read @0x7FE (misaligned) and @0x800 (out of window) -> mem_sel=0, m0_rvalid=1, rdata=0, m0_err=1.
//  M1 lock then drops req mid-burst while M0 waits -> next cycle IDLE, M0 granted following cycle.
//  rst_n low during LOCK1 with a read in flight -> no m1_rvalid, FSM IDLE, first tie after reset goes to M0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory, with bounded burst locking.
// Grants are combinational; read data and error responses are registered per master.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MEM_BYTES = 2048,
  parameter int                MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              lsu_stall,
  output logic              mem_sel,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t             state;
  logic               last_gnt;   // 0 = M0 was granted last, 1 = M1
  logic [CNT_W-1:0]   burst_cnt;

  logic               any_gnt;
  logic               sel_we;
  logic               sel_lock;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               hit;

  // Window check done one bit wider so BASE_ADDR near the top cannot wrap.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ext;
    logic [ADDR_W:0] lo;
    logic [ADDR_W:0] hi;
    ext = {1'b0, a};
    lo  = {1'b0, BASE_ADDR};
    hi  = lo + (ADDR_W+1)'(MEM_BYTES - 4);
    return (ext >= lo) && (ext <= hi) && (a[1:0] == 2'b00);
  endfunction

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (m0_req && m1_req) begin
            m0_gnt = last_gnt;
            m1_gnt = ~last_gnt;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        LOCK0:   m0_gnt = m0_req;
        LOCK1:   m1_gnt = m1_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    any_gnt   = m0_gnt | m1_gnt;
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_lock  = m1_gnt ? m1_lock  : m0_lock;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    hit       = addr_hit(sel_addr);
    mem_sel   = any_gnt & hit;
    mem_wr_en = any_gnt & hit & sel_we;
    mem_rd_en = any_gnt & hit & ~sel_we;
    mem_addr  = any_gnt ? sel_addr  : '0;
    mem_wdata = any_gnt ? sel_wdata : '0;
    lsu_stall = m0_req & ~m0_gnt;
  end

  // Ownership FSM: a lock is released by an unlocked beat, an absent request,
  // or after MAX_BURST consecutive beats so the other master can get in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
    end else begin
      if (any_gnt) last_gnt <= m1_gnt;
      case (state)
        IDLE: begin
          if (any_gnt && sel_lock && (MAX_BURST > 1)) begin
            state     <= m1_gnt ? LOCK1 : LOCK0;
            burst_cnt <= CNT_W'(1);
          end
        end
        LOCK0, LOCK1: begin
          if (any_gnt && sel_lock && (burst_cnt < CNT_W'(MAX_BURST - 1))) begin
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            state     <= IDLE;
            burst_cnt <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  // Response stage: memory read data captured at the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m0_err    <= m0_gnt & ~hit;
      if (m0_gnt && !m0_we) m0_rdata <= hit ? mem_rdata : '0;
      m1_rvalid <= m1_gnt & ~m1_we;
      m1_err    <= m1_gnt & ~hit;
      if (m1_gnt && !m1_we) m1_rdata <= hit ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed sequences, a cycle-level reference model of the
// arbitration rules and a reference memory, plus literal spot checks.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int          ADDR_W    = 32;
  localparam int          DATA_W    = 32;
  localparam logic [31:0] BASE_ADDR = 32'h0;
  localparam int          MEM_BYTES = 2048;
  localparam int          MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        lsu_stall, mem_sel, mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR),
    .MEM_BYTES(MEM_BYTES), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .lsu_stall(lsu_stall), .mem_sel(mem_sel), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the arbiter: combinational read, posedge write.
  logic [31:0] mem_arr [0:511];
  assign mem_rdata = mem_arr[mem_addr[10:2]];
  always @(posedge clk) if (mem_sel && mem_wr_en) mem_arr[mem_addr[10:2]] <= mem_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: owner of the current locked run (-1 none), its length,
  // the last granted master, a reference copy of memory and expected responses.
  int          m_own, m_run, m_last, g, idx;
  logic [31:0] ref_mem [0:511];
  logic        e_rv [2];
  logic        e_er [2];
  logic [31:0] e_rd [2];
  logic [31:0] ca, cwd;
  logic        cwe, clk_lk, chit;
  logic [63:0] la;

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_arr[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    m_own = -1; m_run = 0; m_last = 1;
    for (int i = 0; i < 2; i++) begin
      e_rv[i] = 1'b0; e_er[i] = 1'b0; e_rd[i] = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_m0_gnt", m0_gnt, 0);      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_mem_sel", mem_sel, 0);    chk("rst_mem_wr", mem_wr_en, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0); chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_m0_err", m0_err, 0);      chk("rst_m1_err", m1_err, 0);
      chk("rst_m0_rdata", m0_rdata, 0);  chk("rst_m1_rdata", m1_rdata, 0);
      m_own = -1; m_run = 0; m_last = 1;
      for (int i = 0; i < 2; i++) begin
        e_rv[i] = 1'b0; e_er[i] = 1'b0; e_rd[i] = 32'h0;
      end
    end else begin
      chk("m0_rvalid", m0_rvalid, e_rv[0]); chk("m1_rvalid", m1_rvalid, e_rv[1]);
      chk("m0_err", m0_err, e_er[0]);       chk("m1_err", m1_err, e_er[1]);
      chk("m0_rdata", m0_rdata, e_rd[0]);   chk("m1_rdata", m1_rdata, e_rd[1]);
      g = -1;
      if (m_own < 0) begin
        if (m0_req && m1_req) g = (m_last == 1) ? 0 : 1;
        else if (m0_req)      g = 0;
        else if (m1_req)      g = 1;
      end else if ((m_own == 0 && m0_req) || (m_own == 1 && m1_req)) begin
        g = m_own;
      end
      chk("m0_gnt", m0_gnt, g == 0);
      chk("m1_gnt", m1_gnt, g == 1);
      chk("lsu_stall", lsu_stall, m0_req && (g != 0));
      e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_er[0] = 1'b0; e_er[1] = 1'b0;
      if (g < 0) begin
        chk("idle_mem_sel", mem_sel, 0); chk("idle_mem_rd", mem_rd_en, 0);
        chk("idle_mem_wr", mem_wr_en, 0); chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_wdata", mem_wdata, 0);
        m_own = -1; m_run = 0;
      end else begin
        ca     = (g == 1) ? m1_addr  : m0_addr;
        cwd    = (g == 1) ? m1_wdata : m0_wdata;
        cwe    = (g == 1) ? m1_we    : m0_we;
        clk_lk = (g == 1) ? m1_lock  : m0_lock;
        la     = {32'h0, ca};
        chit   = (la >= 64'(BASE_ADDR)) && (la <= 64'(BASE_ADDR) + 64'(MEM_BYTES - 4))
                 && (ca % 4 == 0);
        idx    = chit ? int'((la - 64'(BASE_ADDR)) >> 2) : 0;
        chk("mem_sel", mem_sel, chit);
        chk("mem_rd_en", mem_rd_en, chit && !cwe);
        chk("mem_wr_en", mem_wr_en, chit && cwe);
        if (chit) chk("mem_addr", mem_addr, ca);
        if (chit && cwe) chk("mem_wdata", mem_wdata, cwd);
        if (!cwe) begin
          e_rv[g] = 1'b1;
          e_rd[g] = chit ? ref_mem[idx] : 32'h0;
        end
        e_er[g] = !chit;
        if (chit && cwe) ref_mem[idx] = cwd;
        m_last = g;
        if (clk_lk) begin
          if (m_own == g) m_run++;
          else begin m_own = g; m_run = 1; end
          if (m_run >= MAX_BURST) begin m_own = -1; m_run = 0; end
        end else begin
          m_own = -1; m_run = 0;
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_neg();
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] miss_addr [3];

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    miss_addr[0] = 32'h7FE; miss_addr[1] = 32'h800; miss_addr[2] = 32'h102;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Contention without lock alternates, M0 first after reset.
    m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h24;
    for (int i = 0; i < 6; i++) begin
      wait_neg();
      chk("alt_m0_gnt", m0_gnt, (i % 2) == 0);
      chk("alt_lsu_stall", lsu_stall, (i % 2) == 1);
      next_cyc();
    end
    m0_req = 0; m1_req = 0;
    next_cyc();

    // Write then read back through M0.
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    wait_neg(); chk("wr_gnt", m0_gnt, 1);
    next_cyc(); m0_we = 0;
    wait_neg(); chk("rd_gnt", m0_gnt, 1);
    next_cyc(); m0_req = 0;
    wait_neg(); chk("rd_rvalid", m0_rvalid, 1); chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    next_cyc();

    // M1 locked writes against a constant M0 read: 8 M1, 1 M0, relock.
    m0_req = 1; m0_addr = 32'h10;
    m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 32'h100; m1_wdata = 32'hA000_0000;
    for (int i = 0; i < 20; i++) begin
      wait_neg();
      chk("burst_m1_gnt", m1_gnt, !(i == 8 || i == 17));
      next_cyc();
      m1_addr = m1_addr + 4; m1_wdata = m1_wdata + 1;
    end
    m0_req = 0; m1_req = 0; m1_lock = 0; m1_we = 0;
    next_cyc(); next_cyc();

    // Out-of-window and misaligned reads, then a write miss.
    for (int i = 0; i < 3; i++) begin
      m0_req = 1; m0_we = 0; m0_addr = miss_addr[i];
      wait_neg(); chk("miss_gnt", m0_gnt, 1); chk("miss_mem_sel", mem_sel, 0);
      next_cyc(); m0_req = 0;
      wait_neg(); chk("miss_rvalid", m0_rvalid, 1); chk("miss_rdata", m0_rdata, 0);
      chk("miss_err", m0_err, 1);
      next_cyc();
    end
    m0_req = 1; m0_we = 1; m0_addr = 32'h900; m0_wdata = 32'h1234_5678;
    next_cyc(); m0_req = 0; m0_we = 0;
    wait_neg(); chk("wmiss_err", m0_err, 1); chk("wmiss_rvalid", m0_rvalid, 0);
    next_cyc();

    // Cross-master readback of a beat written by M1 in the burst.
    m0_req = 1; m0_addr = 32'h104;
    next_cyc(); m0_req = 0;
    wait_neg(); chk("xm_rdata", m0_rdata, 32'hA000_0001);
    next_cyc();

    // M1 abandons its lock while M0 waits.
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_lock = 1; m1_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      wait_neg(); chk("abn_m1_gnt", m1_gnt, 1);
      next_cyc();
    end
    m1_req = 0;
    wait_neg(); chk("abn_m0_wait", m0_gnt, 0); chk("abn_m1_none", m1_gnt, 0);
    chk("abn_stall", lsu_stall, 1);
    next_cyc();
    wait_neg(); chk("abn_m0_gnt", m0_gnt, 1);
    next_cyc(); m0_req = 0; m1_lock = 0;
    next_cyc();

    // Reset during a locked M1 read.
    m0_req = 1; m1_req = 1; m1_lock = 1; m1_addr = 32'h104;
    wait_neg(); chk("rst_lock_gnt", m1_gnt, 1);
    next_cyc(); rst_n = 0;
    wait_neg(); chk("rst_drop_rvalid", m1_rvalid, 0); chk("rst_drop_rdata", m1_rdata, 0);
    next_cyc(); next_cyc();
    rst_n = 1; m1_lock = 0;
    wait_neg(); chk("post_rst_m0", m0_gnt, 1);
    next_cyc();
    wait_neg(); chk("post_rst_m1", m1_gnt, 1);
    next_cyc();
    m0_req = 0; m1_req = 0;
    next_cyc(); next_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
